// File: rtl/rom_word_fetch.sv
// Fetches bursts of 32-bit words from a 1K x 16 synchronous ROM by reading two
// consecutive halfwords per word, then offers each word on a valid/ready port.
module rom_word_fetch (
  input  logic        clk,
  input  logic        resetn,
  output logic [9:0]  rom_addr,
  input  logic [15:0] rom_dout,
  input  logic        start,
  input  logic [9:0]  start_addr,
  input  logic [7:0]  start_len,
  input  logic        abort,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic [9:0]  word_addr,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, ISSUE_LO, ISSUE_HI, CAPTURE_HI, OUT} state_t;

  state_t      state, state_nxt;
  logic [9:0]  ptr;
  logic [8:0]  remaining;
  logic [15:0] lo;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = ISSUE_LO;
      ISSUE_LO:   state_nxt = ISSUE_HI;
      ISSUE_HI:   state_nxt = CAPTURE_HI;
      CAPTURE_HI: state_nxt = OUT;
      OUT:        if (word_valid && word_ready)
                    state_nxt = (remaining > 9'd1) ? ISSUE_LO : IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Pointer, word assembly and handshake registers; the ROM answers one cycle after ptr
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr        <= 10'd0;
      remaining  <= 9'd0;
      lo         <= 16'd0;
      word_valid <= 1'b0;
      word_data  <= 32'd0;
      word_addr  <= 10'd0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        word_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start && !abort) begin
            ptr       <= start_addr;
            remaining <= (start_len == 8'd0) ? 9'd256 : {1'b0, start_len};
          end
          ISSUE_LO: ptr <= ptr + 10'd1;
          ISSUE_HI: begin
            lo  <= rom_dout;
            ptr <= ptr + 10'd1;
          end
          CAPTURE_HI: begin
            word_data  <= {rom_dout, lo};
            word_addr  <= ptr - 10'd2;
            word_valid <= 1'b1;
          end
          OUT: if (word_valid && word_ready) begin
            word_valid <= 1'b0;
            remaining  <= remaining - 9'd1;
            if (remaining <= 9'd1) done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Moore outputs
  always_comb begin
    busy     = (state != IDLE);
    rom_addr = ptr;
  end

endmodule

// File: tb/tb_rom_word_fetch.sv
// Bench for rom_word_fetch: a behavioural ROM plus a word-list reference model
// built directly from burst address/length, with directed and random bursts.
module tb_rom_word_fetch;

  logic        clk;
  logic        resetn;
  logic [9:0]  rom_addr;
  logic [15:0] rom_dout;
  logic        start;
  logic [9:0]  start_addr;
  logic [7:0]  start_len;
  logic        abort;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [9:0]  word_addr;
  logic        busy;
  logic        done;

  logic [15:0] mem [1024];
  int total_checks = 0;
  int bad_checks   = 0;
  int done_count   = 0;

  rom_word_fetch dut (
    .clk        (clk),
    .resetn     (resetn),
    .rom_addr   (rom_addr),
    .rom_dout   (rom_dout),
    .start      (start),
    .start_addr (start_addr),
    .start_len  (start_len),
    .abort      (abort),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_addr  (word_addr),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_dout <= mem[rom_addr];

  always @(negedge clk) if (done) done_count++;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full burst, called at a negedge with the block idle
  task automatic applyStimulus(input logic [9:0] sa, input logic [7:0] sl,
                               input int hold_idx, input int hold_cycles, input bit rand_hold);
    int          len, n, hold, done_before;
    logic [9:0]  a, a_hi;
    logic [31:0] exp_data;
    len         = (sl == 8'd0) ? 256 : int'(sl);
    done_before = done_count;
    start = 1'b1; start_addr = sa; start_len = sl; word_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < len; k++) begin
      n = 0;
      while (!word_valid && n < 20) begin
        start      = 1'($urandom);
        start_addr = 10'($urandom);
        start_len  = 8'($urandom);
        word_ready = 1'($urandom);
        @(negedge clk);
        n++;
      end
      start = 1'b0; word_ready = 1'b0;
      checkOutput("valid_timeout", 32'(word_valid), 32'd1);
      if (k == 0) checkOutput("first_latency", 32'(n), 32'd3);
      a        = 10'((int'(sa) + 2 * k) % 1024);
      a_hi     = a + 10'd1;
      exp_data = {mem[a_hi], mem[a]};
      checkOutput("word_data", word_data, exp_data);
      checkOutput("word_addr", 32'(word_addr), 32'(a));
      hold = (k == hold_idx) ? hold_cycles : (rand_hold ? int'($urandom_range(0, 3)) : 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checkOutput("hold_valid", 32'(word_valid), 32'd1);
        checkOutput("hold_data", word_data, exp_data);
        checkOutput("hold_addr", 32'(word_addr), 32'(a));
      end
      word_ready = 1'b1;
      @(negedge clk);
      word_ready = 1'b0;
      checkOutput("valid_drop", 32'(word_valid), 32'd0);
      checkOutput("done", 32'(done), (k == len - 1) ? 32'd1 : 32'd0);
      if (k == len - 1) checkOutput("busy_end", 32'(busy), 32'd0);
    end
    @(negedge clk);
    checkOutput("done_width", 32'(done), 32'd0);
    checkOutput("done_count", 32'(done_count - done_before), 32'd1);
  endtask

  // Four-word burst aborted while the second word is being captured
  task automatic runAbort(input logic [9:0] sa);
    int         n, done_before;
    logic [9:0] a_hi;
    done_before = done_count;
    start = 1'b1; start_addr = sa; start_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!word_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    a_hi = sa + 10'd1;
    checkOutput("abort_w0_valid", 32'(word_valid), 32'd1);
    checkOutput("abort_w0_data", word_data, {mem[a_hi], mem[sa]});
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1; word_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; word_ready = 1'b0;
    checkOutput("abort_valid", 32'(word_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("abort_idle_valid", 32'(word_valid), 32'd0);
      checkOutput("abort_idle_busy", 32'(busy), 32'd0);
    end
    checkOutput("abort_no_done", 32'(done_count - done_before), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; word_ready = 1'b0;
    start_addr = 10'd0; start_len = 8'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
    #12;
    checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("rst_valid", 32'(word_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_data", word_data, 32'd0);
    checkOutput("rst_addr", 32'(word_addr), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    applyStimulus(10'h010, 8'd2, -1, 0, 1'b0);
    applyStimulus(10'h3FF, 8'd1, -1, 0, 1'b0);
    applyStimulus(10'h123, 8'd3, 0, 5, 1'b0);
    runAbort(10'h040);
    applyStimulus(10'h080, 8'd2, -1, 0, 1'b0);

    // Reset in the middle of a word offer
    start = 1'b1; start_addr = 10'h200; start_len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    checkOutput("pre_reset_valid", 32'(word_valid), 32'd1);
    resetn = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(word_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("midrst_data", word_data, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("postrst_busy", 32'(busy), 32'd0);
      checkOutput("postrst_valid", 32'(word_valid), 32'd0);
    end

    start = 1'b1; abort = 1'b1; start_addr = 10'h055; start_len = 8'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checkOutput("start_abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("start_abort_busy2", 32'(busy), 32'd0);

    applyStimulus(10'h000, 8'd0, -1, 0, 1'b0);

    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int b = 0; b < 20; b++)
      applyStimulus(10'($urandom), 8'($urandom_range(1, 12)), -1, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
